vga_native_regfile: RTL and testbench

- Register file on the native side of vga_axil_slave_fsm. It consumes the native write/read strobes that the FSM produces and returns read data to it.
- It holds the VGA configuration: control, timing and framebuffer base.
- It collects frame/underflow status from the timing/pixel pipeline and drives a level interrupt.
- Timing/base registers are double-buffered and applied to the video pipeline only at frame boundaries.

---
 rtl/vga_native_regfile.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_native_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_native_regfile.sv
// rtl/vga_native_regfile.sv - VGA configuration/status register file on the native side of the AXI-Lite slave
//
// Purpose: holds CTRL / H_TIMING / V_TIMING / FB_BASE shadow registers, applies
// them to the video pipeline (every cycle while disabled, only at frame_start_i
// while enabled), collects STATUS (W1C), counts frames and drives a level irq.
// Optional feature macro: VGA_REGFILE_LINE_CNT_EN (adds line_start_i and LINE_CNT at 0x7).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   write_en/addr_write/data2native  native write strobe, word address, data
//   read_en_sync/addr_read       native read strobe, word address
//   data2axil                    registered read data
//   frame_start_i, underflow_i   status pulses from the video pipeline
//   line_start_i                 line pulse (only with VGA_REGFILE_LINE_CNT_EN)
//   enable_o, test_pattern_o     active CTRL bits
//   h/v_active_o, h/v_total_o    active timing
//   fb_base_o                    active framebuffer base
//   irq_o                        level interrupt
`timescale 1ns/1ps

module vga_native_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'h56474131
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] addr_write,
  input  logic [DATA_WIDTH-1:0] data2native,
  input  logic                  read_en_sync,
  input  logic [ADDR_WIDTH-1:0] addr_read,
  output logic [DATA_WIDTH-1:0] data2axil,
  input  logic                  frame_start_i,
  input  logic                  underflow_i,
`ifdef VGA_REGFILE_LINE_CNT_EN
  input  logic                  line_start_i,
`endif
  output logic                  enable_o,
  output logic                  test_pattern_o,
  output logic [11:0]           h_active_o,
  output logic [11:0]           h_total_o,
  output logic [11:0]           v_active_o,
  output logic [11:0]           v_total_o,
  output logic [DATA_WIDTH-1:0] fb_base_o,
  output logic                  irq_o
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_HTIM   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_VTIM   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_FBASE  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_FCNT   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_ID     = ADDR_WIDTH'(6);
`ifdef VGA_REGFILE_LINE_CNT_EN
  localparam logic [ADDR_WIDTH-1:0] A_LCNT   = ADDR_WIDTH'(7);
`endif

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [11:0]           h_act_q, h_act_d, h_tot_q, h_tot_d;
  logic [11:0]           v_act_q, v_act_d, v_tot_q, v_tot_d;
  logic [DATA_WIDTH-1:0] fb_q, fb_d;
  logic [1:0]            status_q, status_d;
  logic [DATA_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [11:0]           a_h_act_q, a_h_act_d, a_h_tot_q, a_h_tot_d;
  logic [11:0]           a_v_act_q, a_v_act_d, a_v_tot_q, a_v_tot_d;
  logic [DATA_WIDTH-1:0] a_fb_q, a_fb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic                  load_active;
`ifdef VGA_REGFILE_LINE_CNT_EN
  logic [11:0]           line_cnt_q, line_cnt_d;
`endif

  logic wr_ctrl, wr_htim, wr_vtim, wr_fbase, wr_status;
  assign wr_ctrl   = write_en && (addr_write == A_CTRL);
  assign wr_htim   = write_en && (addr_write == A_HTIM);
  assign wr_vtim   = write_en && (addr_write == A_VTIM);
  assign wr_fbase  = write_en && (addr_write == A_FBASE);
  assign wr_status = write_en && (addr_write == A_STATUS);

  // Apply FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Apply FSM: next state follows writes of CTRL.enable
  always_comb begin
    state_d = state_q;
    if (wr_ctrl) state_d = data2native[0] ? ST_RUN : ST_IDLE;
  end

  // Apply FSM: output. Active copies take the pre-write shadow value, so a
  // shadow write coinciding with frame_start_i waits for the next frame.
  always_comb begin
    load_active = (state_q == ST_IDLE) || frame_start_i;
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    h_act_d     = h_act_q;
    h_tot_d     = h_tot_q;
    v_act_d     = v_act_q;
    v_tot_d     = v_tot_q;
    fb_d        = fb_q;
    a_h_act_d   = a_h_act_q;
    a_h_tot_d   = a_h_tot_q;
    a_v_act_d   = a_v_act_q;
    a_v_tot_d   = a_v_tot_q;
    a_fb_d      = a_fb_q;
    frame_cnt_d = frame_cnt_q;
    rdata_d     = rdata_q;

    if (wr_ctrl)  ctrl_d = data2native[2:0];
    if (wr_htim) begin
      h_act_d = data2native[11:0];
      h_tot_d = data2native[27:16];
    end
    if (wr_vtim) begin
      v_act_d = data2native[11:0];
      v_tot_d = data2native[27:16];
    end
    if (wr_fbase) fb_d = data2native;

    if (load_active) begin
      a_h_act_d = h_act_q;
      a_h_tot_d = h_tot_q;
      a_v_act_d = v_act_q;
      a_v_tot_d = v_tot_q;
      a_fb_d    = fb_q;
    end

    // W1C clear first, then hardware set so a coincident set wins
    status_d = status_q;
    if (wr_status) status_d = status_d & ~data2native[1:0];
    status_d = status_d | {underflow_i, frame_start_i};

    if (frame_start_i && ctrl_q[0]) frame_cnt_d = frame_cnt_q + 1'b1;

    // irq follows the values being registered this edge
    irq_d = ctrl_d[1] && (|status_d);

    // Read mux uses current (pre-write) register values
    if (read_en_sync) begin
      rdata_d = '0;
      case (addr_read)
        A_CTRL:   rdata_d[2:0] = ctrl_q;
        A_HTIM:   begin rdata_d[11:0] = h_act_q; rdata_d[27:16] = h_tot_q; end
        A_VTIM:   begin rdata_d[11:0] = v_act_q; rdata_d[27:16] = v_tot_q; end
        A_FBASE:  rdata_d = fb_q;
        A_STATUS: rdata_d[1:0] = status_q;
        A_FCNT:   rdata_d = frame_cnt_q;
        A_ID:     rdata_d = ID_VALUE;
`ifdef VGA_REGFILE_LINE_CNT_EN
        A_LCNT:   rdata_d[11:0] = line_cnt_q;
`endif
        default:  rdata_d = '0;
      endcase
    end
  end

`ifdef VGA_REGFILE_LINE_CNT_EN
  // frame_start_i clear wins over line increment
  always_comb begin
    line_cnt_d = line_cnt_q;
    if (frame_start_i)     line_cnt_d = '0;
    else if (line_start_i) line_cnt_d = line_cnt_q + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) line_cnt_q <= '0;
    else     line_cnt_q <= line_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      h_act_q     <= 12'd640;
      h_tot_q     <= 12'd800;
      v_act_q     <= 12'd480;
      v_tot_q     <= 12'd525;
      fb_q        <= '0;
      a_h_act_q   <= 12'd640;
      a_h_tot_q   <= 12'd800;
      a_v_act_q   <= 12'd480;
      a_v_tot_q   <= 12'd525;
      a_fb_q      <= '0;
      status_q    <= '0;
      frame_cnt_q <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      h_act_q     <= h_act_d;
      h_tot_q     <= h_tot_d;
      v_act_q     <= v_act_d;
      v_tot_q     <= v_tot_d;
      fb_q        <= fb_d;
      a_h_act_q   <= a_h_act_d;
      a_h_tot_q   <= a_h_tot_d;
      a_v_act_q   <= a_v_act_d;
      a_v_tot_q   <= a_v_tot_d;
      a_fb_q      <= a_fb_d;
      status_q    <= status_d;
      frame_cnt_q <= frame_cnt_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign data2axil      = rdata_q;
  assign enable_o       = ctrl_q[0];
  assign test_pattern_o = ctrl_q[2];
  assign h_active_o     = a_h_act_q;
  assign h_total_o      = a_h_tot_q;
  assign v_active_o     = a_v_act_q;
  assign v_total_o      = a_v_tot_q;
  assign fb_base_o      = a_fb_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_vga_native_regfile.sv
// tb/tb_vga_native_regfile.sv - self-checking bench for vga_native_regfile
`timescale 1ns/1ps

module tb_vga_native_regfile;

  logic        clk = 1'b0;
  logic        rst, write_en, read_en_sync, frame_start_i, underflow_i, line_start_i;
  logic [7:0]  addr_write, addr_read;
  logic [31:0] data2native, data2axil, fb_base_o;
  logic        enable_o, test_pattern_o, irq_o;
  logic [11:0] h_active_o, h_total_o, v_active_o, v_total_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_native_regfile dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .addr_write(addr_write), .data2native(data2native),
    .read_en_sync(read_en_sync), .addr_read(addr_read), .data2axil(data2axil),
    .frame_start_i(frame_start_i), .underflow_i(underflow_i),
`ifdef VGA_REGFILE_LINE_CNT_EN
    .line_start_i(line_start_i),
`endif
    .enable_o(enable_o), .test_pattern_o(test_pattern_o),
    .h_active_o(h_active_o), .h_total_o(h_total_o),
    .v_active_o(v_active_o), .v_total_o(v_total_o),
    .fb_base_o(fb_base_o), .irq_o(irq_o)
  );

  // Reference model state: register contents as seen through the map
  logic [2:0]  m_ctrl;
  logic [11:0] m_ha, m_ht, m_va, m_vt, m_a_ha, m_a_ht, m_a_va, m_a_vt, m_line;
  logic [31:0] m_fb, m_a_fb, m_cnt, m_rd;
  logic [1:0]  m_st;
  logic        m_irq;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h0: return {29'd0, m_ctrl};
      8'h1: return {4'd0, m_ht, 4'd0, m_ha};
      8'h2: return {4'd0, m_vt, 4'd0, m_va};
      8'h3: return m_fb;
      8'h4: return {30'd0, m_st};
      8'h5: return m_cnt;
      8'h6: return 32'h56474131;
`ifdef VGA_REGFILE_LINE_CNT_EN
      8'h7: return {20'd0, m_line};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic r, we, input logic [7:0] wa, input logic [31:0] wd,
                            input logic re, input logic [7:0] ra, input logic fs, uf, ls);
    if (r) begin
      m_ctrl = 0; m_ha = 640; m_ht = 800; m_va = 480; m_vt = 525; m_fb = 0;
      m_a_ha = 640; m_a_ht = 800; m_a_va = 480; m_a_vt = 525; m_a_fb = 0;
      m_st = 0; m_cnt = 0; m_rd = 0; m_irq = 0; m_line = 0;
      return;
    end
    if (re) m_rd = m_read(ra);
    if (!m_ctrl[0] || fs) begin
      m_a_ha = m_ha; m_a_ht = m_ht; m_a_va = m_va; m_a_vt = m_vt; m_a_fb = m_fb;
    end
    if (fs && m_ctrl[0]) m_cnt = m_cnt + 1;
    if (fs) m_line = 0; else if (ls) m_line = m_line + 1;
    if (we && wa == 8'h4) m_st = m_st & ~wd[1:0];
    m_st = m_st | {uf, fs};
    if (we) begin
      case (wa)
        8'h0: m_ctrl = wd[2:0];
        8'h1: begin m_ha = wd[11:0]; m_ht = wd[27:16]; end
        8'h2: begin m_va = wd[11:0]; m_vt = wd[27:16]; end
        8'h3: m_fb = wd;
        default: ;
      endcase
    end
    m_irq = m_ctrl[1] && (m_st != 0);
  endtask

  // One clock: drive inputs, advance model, step past the edge
  task automatic cycle(input logic r, we, input logic [7:0] wa, input logic [31:0] wd,
                       input logic re, input logic [7:0] ra, input logic fs, uf, ls);
    rst = r; write_en = we; addr_write = wa; data2native = wd;
    read_en_sync = re; addr_read = ra; frame_start_i = fs; underflow_i = uf; line_start_i = ls;
    model_step(r, we, wa, wd, re, ra, fs, uf, ls);
    @(posedge clk); #1;
    rst = 0; write_en = 0; read_en_sync = 0; frame_start_i = 0; underflow_i = 0; line_start_i = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cycle(0, 1, a, d, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(0, 0, 0, 0, 1, a, 0, 0, 0);
  endtask

  task automatic idle(input logic fs);
    cycle(0, 0, 0, 0, 0, 0, fs, 0, 0);
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", enable_o); end
    n_checks++; if (test_pattern_o !== 1'b0) begin n_fail++; $display("FAIL reset_tp: got %b want 0", test_pattern_o); end
    n_checks++; if ({h_total_o, h_active_o} !== {12'd800, 12'd640}) begin n_fail++; $display("FAIL reset_h: got %0d/%0d want 800/640", h_total_o, h_active_o); end
    n_checks++; if ({v_total_o, v_active_o} !== {12'd525, 12'd480}) begin n_fail++; $display("FAIL reset_v: got %0d/%0d want 525/480", v_total_o, v_active_o); end
    n_checks++; if (fb_base_o !== 32'd0) begin n_fail++; $display("FAIL reset_fb: got %h want 0", fb_base_o); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    n_checks++; if (data2axil !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", data2axil); end
    rd(8'h1);
    n_checks++; if (data2axil !== 32'h03200280) begin n_fail++; $display("FAIL reset_read_h: got %h want 03200280", data2axil); end
    rd(8'h2);
    n_checks++; if (data2axil !== 32'h020D01E0) begin n_fail++; $display("FAIL reset_read_v: got %h want 020d01e0", data2axil); end
    rd(8'h6);
    n_checks++; if (data2axil !== 32'h56474131) begin n_fail++; $display("FAIL reset_read_id: got %h want 56474131", data2axil); end
    rd(8'h9);
    n_checks++; if (data2axil !== 32'd0) begin n_fail++; $display("FAIL reset_read_unmapped: got %h want 0", data2axil); end
    idle(0);
    n_checks++; if (data2axil !== 32'd0) begin n_fail++; $display("FAIL read_hold: got %h want 0", data2axil); end
  endtask

  task automatic test_idle_apply;
    wr(8'h3, 32'hDEAD0000);
    n_checks++; if (fb_base_o !== 32'd0) begin n_fail++; $display("FAIL idle_fb_early: got %h want 0", fb_base_o); end
    idle(0);
    n_checks++; if (fb_base_o !== 32'hDEAD0000) begin n_fail++; $display("FAIL idle_fb: got %h want dead0000", fb_base_o); end
  endtask

  task automatic test_run_apply;
    wr(8'h0, 32'h1);
    n_checks++; if (enable_o !== 1'b1) begin n_fail++; $display("FAIL run_enable: got %b want 1", enable_o); end
    wr(8'h1, 32'h035A02D0);
    idle(0); idle(0); idle(0);
    n_checks++; if (h_active_o !== 12'd640) begin n_fail++; $display("FAIL run_h_hold: got %0d want 640", h_active_o); end
    idle(1);
    n_checks++; if ({h_total_o, h_active_o} !== {12'd858, 12'd720}) begin n_fail++; $display("FAIL run_h_apply: got %0d/%0d want 858/720", h_total_o, h_active_o); end
    // write coinciding with frame start waits for the following frame
    cycle(0, 1, 8'h3, 32'h12345678, 0, 0, 1, 0, 0);
    idle(0);
    n_checks++; if (fb_base_o !== 32'hDEAD0000) begin n_fail++; $display("FAIL run_fb_coincide: got %h want dead0000", fb_base_o); end
    idle(1);
    n_checks++; if (fb_base_o !== 32'h12345678) begin n_fail++; $display("FAIL run_fb_next: got %h want 12345678", fb_base_o); end
    rd(8'h5);
    n_checks++; if (data2axil !== 32'd3) begin n_fail++; $display("FAIL run_frame_cnt: got %0d want 3", data2axil); end
  endtask

  task automatic test_rw_same;
    cycle(0, 1, 8'h3, 32'hA5A5A5A5, 1, 8'h3, 0, 0, 0);
    n_checks++; if (data2axil !== 32'h12345678) begin n_fail++; $display("FAIL rw_same_pre: got %h want 12345678", data2axil); end
    rd(8'h3);
    n_checks++; if (data2axil !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rw_same_post: got %h want a5a5a5a5", data2axil); end
  endtask

  task automatic test_status_irq;
    wr(8'h4, 32'h3);
    wr(8'h0, 32'h3);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear_start: got %b want 0", irq_o); end
    idle(1);
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq_o); end
    rd(8'h4);
    n_checks++; if (data2axil !== 32'h1) begin n_fail++; $display("FAIL status_frame: got %h want 1", data2axil); end
    wr(8'h4, 32'h1);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b want 0", irq_o); end
    rd(8'h4);
    n_checks++; if (data2axil !== 32'h0) begin n_fail++; $display("FAIL status_w1c: got %h want 0", data2axil); end
    cycle(0, 1, 8'h4, 32'h2, 0, 0, 0, 1, 0);
    rd(8'h4);
    n_checks++; if (data2axil !== 32'h2) begin n_fail++; $display("FAIL status_set_wins: got %h want 2", data2axil); end
    n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b want 1", irq_o); end
  endtask

  task automatic test_mid_reset;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    wr(8'h0, 32'h7);
    for (int i = 0; i < 5; i++) idle(1);
    rd(8'h5);
    n_checks++; if (data2axil !== 32'd5) begin n_fail++; $display("FAIL mid_cnt5: got %0d want 5", data2axil); end
    cycle(1, 1, 8'h3, 32'hFFFFFFFF, 1, 8'h6, 1, 1, 0);
    n_checks++; if (data2axil !== 32'd0) begin n_fail++; $display("FAIL mid_rdata: got %h want 0", data2axil); end
    n_checks++; if ({enable_o, test_pattern_o, irq_o} !== 3'b000) begin n_fail++; $display("FAIL mid_ctrl: got %b want 000", {enable_o, test_pattern_o, irq_o}); end
    n_checks++; if ({h_active_o, v_active_o, fb_base_o} !== {12'd640, 12'd480, 32'd0}) begin n_fail++; $display("FAIL mid_active: got %0d %0d %h want 640 480 0", h_active_o, v_active_o, fb_base_o); end
    rd(8'h5);
    n_checks++; if (data2axil !== 32'd0) begin n_fail++; $display("FAIL mid_cnt0: got %0d want 0", data2axil); end
    rd(8'h3);
    n_checks++; if (data2axil !== 32'd0) begin n_fail++; $display("FAIL mid_strobe_drop: got %h want 0", data2axil); end
  endtask

  task automatic test_random;
    logic       we, re, fs, uf, ls, r;
    logic [7:0] wa, ra;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 150) == 0);
      we = ($urandom_range(0, 2) == 0);
      wa = 8'($urandom_range(0, 9));
      re = ($urandom_range(0, 1) == 0);
      ra = 8'($urandom_range(0, 9));
      fs = ($urandom_range(0, 7) == 0);
      uf = ($urandom_range(0, 7) == 0);
      ls = ($urandom_range(0, 2) == 0);
      cycle(r, we, wa, $urandom, re, ra, fs, uf, ls);
      n_checks++; if (data2axil !== m_rd) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, data2axil, m_rd); end
      n_checks++; if ({enable_o, test_pattern_o, irq_o} !== {m_ctrl[0], m_ctrl[2], m_irq}) begin n_fail++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {enable_o, test_pattern_o, irq_o}, {m_ctrl[0], m_ctrl[2], m_irq}); end
      n_checks++; if ({h_total_o, h_active_o, v_total_o, v_active_o} !== {m_a_ht, m_a_ha, m_a_vt, m_a_va}) begin n_fail++; $display("FAIL rand_timing[%0d]: got %h want %h", i, {h_total_o, h_active_o, v_total_o, v_active_o}, {m_a_ht, m_a_ha, m_a_vt, m_a_va}); end
      n_checks++; if (fb_base_o !== m_a_fb) begin n_fail++; $display("FAIL rand_fb[%0d]: got %h want %h", i, fb_base_o, m_a_fb); end
    end
    // final readback of every mapped register
    for (int a = 0; a < 10; a++) begin
      rd(8'(a));
      n_checks++; if (data2axil !== m_rd) begin n_fail++; $display("FAIL rand_readback[%0d]: got %h want %h", a, data2axil, m_rd); end
    end
  endtask

  initial begin
    rst = 1; write_en = 0; read_en_sync = 0; frame_start_i = 0; underflow_i = 0; line_start_i = 0;
    addr_write = 0; addr_read = 0; data2native = 0;
    test_reset();
    test_idle_apply();
    test_run_apply();
    test_rw_same();
    test_status_irq();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
